// File: rtl/playfield_renderer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | playfield_renderer_if : timing-side inputs and colour outputs of the     |
// | Pong playfield renderer.                    Revision 1.0                 |
// +--------------------------------------------------------------------------+
interface playfield_renderer_if;
   logic       pix_en;
   logic [9:0] x;
   logic [9:0] y;
   logic       video_on;
   logic       frame_start;
   logic       score_evt;
   logic       board_on;
   logic [2:0] r;
   logic [2:0] g;
   logic [1:0] b;
   logic       flashing;

   modport master (
      output pix_en, x, y, video_on, frame_start, score_evt,
      input  board_on, r, g, b, flashing
   );

   modport slave (
      input  pix_en, x, y, video_on, frame_start, score_evt,
      output board_on, r, g, b, flashing
   );
endinterface
`default_nettype wire

// File: rtl/playfield_renderer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | playfield_renderer : registered walls + dashed net with score flash.     |
// | Optional macro NET_SCROLL_EN scrolls the net dashes one line per frame.  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module playfield_renderer #(
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned WALL_T    = 10,
   parameter int unsigned NET_X     = 315,
   parameter int unsigned NET_W     = 10,
   parameter int unsigned DASH_P    = 16,
   parameter int unsigned DASH_GAP  = 8,
   parameter logic [7:0]  COLOR     = 8'hDB,
   parameter int unsigned FLASH_FR  = 30,
   parameter int unsigned FLASH_TGL = 4
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   playfield_renderer_if.slave bus
);

   localparam int unsigned OFS_W = $clog2(DASH_P);

   localparam logic [9:0]  c_wall_top  = 10'(WALL_T);
   localparam logic [9:0]  c_wall_bot  = 10'(V_ACTIVE - WALL_T);
   localparam logic [9:0]  c_net_lo    = 10'(NET_X);
   localparam logic [9:0]  c_net_hi    = 10'(NET_X + NET_W);
   localparam logic [10:0] c_dash_mask = 11'(DASH_P - 1);
   localparam logic [10:0] c_dash_gap  = 11'(DASH_GAP);
   localparam logic [7:0]  c_flash_fr  = 8'(FLASH_FR);
   localparam logic [7:0]  c_flash_tgl = 8'(FLASH_TGL);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLASH = 1'b1
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] fcnt_q, fcnt_d;
   logic [7:0] tcnt_q, tcnt_d;
   logic       phase_q, phase_d;
   logic       board_on_q, board_on_d;
   logic [7:0] rgb_q, rgb_d;

   logic [OFS_W-1:0] w_ofs;
   logic [10:0]      w_dash_sum;
   logic             w_dash;
   logic             w_hit;
   logic [7:0]       w_color;

   // ------------------------------------------------------------------------
   // Net dash offset
   // ------------------------------------------------------------------------
`ifdef NET_SCROLL_EN
   logic [OFS_W-1:0] ofs_q, ofs_d;

   // Wraps naturally at DASH_P because DASH_P is a power of two.
   always_comb begin
      ofs_d = ofs_q;
      if (bus.frame_start) begin
         ofs_d = ofs_q + OFS_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ofs_q <= '0;
      end else begin
         ofs_q <= ofs_d;
      end
   end

   assign w_ofs = ofs_q;
`else
   assign w_ofs = '0;
`endif

   // ------------------------------------------------------------------------
   // Geometry
   // ------------------------------------------------------------------------
   assign w_dash_sum = {1'b0, bus.y} + {{(11 - OFS_W){1'b0}}, w_ofs};
   assign w_dash     = (w_dash_sum & c_dash_mask) > c_dash_gap;

   assign w_hit = (bus.y < c_wall_top) |
                  (bus.y > c_wall_bot) |
                  ((bus.x > c_net_lo) & (bus.x < c_net_hi) & w_dash);

   assign w_color = ((state_q == ST_FLASH) && phase_q) ? ~COLOR : COLOR;

   // ------------------------------------------------------------------------
   // Pixel pipeline stage
   // ------------------------------------------------------------------------
   always_comb begin
      board_on_d = board_on_q;
      rgb_d      = rgb_q;
      if (bus.pix_en) begin
         board_on_d = bus.video_on & w_hit;
         rgb_d      = (bus.video_on & w_hit) ? w_color : 8'h00;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         board_on_q <= 1'b0;
         rgb_q      <= 8'h00;
      end else begin
         board_on_q <= board_on_d;
         rgb_q      <= rgb_d;
      end
   end

   // ------------------------------------------------------------------------
   // Score-flash state machine
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         fcnt_q  <= 8'd0;
         tcnt_q  <= 8'd0;
         phase_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         tcnt_q  <= tcnt_d;
         phase_q <= phase_d;
      end
   end

   // A score event always takes priority, so a coincident frame_start is ignored.
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      tcnt_d  = tcnt_q;
      phase_d = phase_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.score_evt) begin
               state_d = ST_FLASH;
               fcnt_d  = c_flash_fr;
               tcnt_d  = c_flash_tgl;
               phase_d = 1'b1;
            end
         end
         ST_FLASH: begin
            if (bus.score_evt) begin
               fcnt_d  = c_flash_fr;
               tcnt_d  = c_flash_tgl;
               phase_d = 1'b1;
            end else if (bus.frame_start) begin
               if (fcnt_q == 8'd1) begin
                  state_d = ST_IDLE;
                  fcnt_d  = 8'd0;
                  tcnt_d  = 8'd0;
                  phase_d = 1'b0;
               end else begin
                  fcnt_d = fcnt_q - 8'd1;
                  if (tcnt_q == 8'd1) begin
                     tcnt_d  = c_flash_tgl;
                     phase_d = ~phase_q;
                  end else begin
                     tcnt_d = tcnt_q - 8'd1;
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.board_on = board_on_q;
   assign bus.r        = rgb_q[7:5];
   assign bus.g        = rgb_q[4:2];
   assign bus.b        = rgb_q[1:0];
   assign bus.flashing = (state_q == ST_FLASH);

endmodule
`default_nettype wire

// File: tb/tb_playfield_renderer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_playfield_renderer : directed + random checks against a frame-level   |
// | reference model.                            Revision 1.0                 |
// +--------------------------------------------------------------------------+
module tb_playfield_renderer;

   localparam int V_ACTIVE  = 480;
   localparam int WALL_T    = 10;
   localparam int NET_X     = 315;
   localparam int NET_W     = 10;
   localparam int DASH_P    = 16;
   localparam int DASH_GAP  = 8;
   localparam logic [7:0] COLOR = 8'hDB;
   localparam int FLASH_FR  = 30;
   localparam int FLASH_TGL = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   playfield_renderer_if bus ();

   playfield_renderer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: flash tracked as "frames since last score".
   bit         m_flash    = 1'b0;
   int         m_fr_since = 0;
   int         m_frames   = 0;
   logic       m_board    = 1'b0;
   logic [7:0] m_rgb      = 8'h00;

   function automatic int ref_ofs();
`ifdef NET_SCROLL_EN
      return m_frames % DASH_P;
`else
      return 0;
`endif
   endfunction

   function automatic bit ref_hit(input int xx, input int yy, input int o);
      bit dash;
      dash = ((yy + o) % DASH_P) > DASH_GAP;
      return (yy < WALL_T) || (yy > V_ACTIVE - WALL_T) ||
             (xx > NET_X && xx < NET_X + NET_W && dash);
   endfunction

   function automatic logic [7:0] ref_color();
      if (m_flash && ((m_fr_since / FLASH_TGL) % 2 == 0)) return ~COLOR;
      return COLOR;
   endfunction

   task automatic check_all(input string tag);
      n_cmp++;
      assert (bus.board_on === m_board) else begin
         n_bad++;
         $error("FAIL %s board_on got %0b want %0b", tag, bus.board_on, m_board);
      end
      n_cmp++;
      assert ({bus.r, bus.g, bus.b} === m_rgb) else begin
         n_bad++;
         $error("FAIL %s rgb got %h want %h", tag, {bus.r, bus.g, bus.b}, m_rgb);
      end
      n_cmp++;
      assert (bus.flashing === m_flash) else begin
         n_bad++;
         $error("FAIL %s flashing got %0b want %0b", tag, bus.flashing, m_flash);
      end
   endtask

   // Called at posedge+1; drives one cycle of inputs and checks before and after the edge.
   task automatic tick(input bit pe, input int xx, input int yy, input bit vo,
                       input bit fs, input bit se, input string tag);
      bus.pix_en      = pe;
      bus.x           = 10'(xx);
      bus.y           = 10'(yy);
      bus.video_on    = vo;
      bus.frame_start = fs;
      bus.score_evt   = se;
      #2;
      check_all({tag, "/pre"});
      if (pe) begin
         m_board = vo && ref_hit(xx, yy, ref_ofs());
         m_rgb   = m_board ? ref_color() : 8'h00;
      end
      @(posedge clk);
      #1;
      if (se) begin
         m_flash    = 1'b1;
         m_fr_since = 0;
      end else if (fs && m_flash) begin
         m_fr_since++;
         if (m_fr_since >= FLASH_FR) m_flash = 1'b0;
      end
      if (fs) m_frames++;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      bus.pix_en      = 1'b0;
      bus.x           = '0;
      bus.y           = '0;
      bus.video_on    = 1'b0;
      bus.frame_start = 1'b0;
      bus.score_evt   = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      m_flash    = 1'b0;
      m_fr_since = 0;
      m_frames   = 0;
      m_board    = 1'b0;
      m_rgb      = 8'h00;
      check_all(tag);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.pix_en      = 1'b0;
      bus.x           = '0;
      bus.y           = '0;
      bus.video_on    = 1'b0;
      bus.frame_start = 1'b0;
      bus.score_evt   = 1'b0;
      @(posedge clk);
      #1;
      do_reset("reset_init");

      // Geometry sweep
      tick(1, 100,   9, 1, 0, 0, "top_y9");
      tick(1, 100,  10, 1, 0, 0, "top_y10");
      tick(1, 100, 470, 1, 0, 0, "bot_y470");
      tick(1, 100, 471, 1, 0, 0, "bot_y471");
      tick(1, 320,   9, 1, 0, 0, "net_y9");
      tick(1, 320,   8, 1, 0, 0, "net_y8");
      tick(1, 320, 201, 1, 0, 0, "net_mid");
      tick(1, 315, 201, 1, 0, 0, "net_x315");
      tick(1, 325, 201, 1, 0, 0, "net_x325");
      tick(1, 316, 201, 1, 0, 0, "net_x316");
      tick(1, 324, 201, 1, 0, 0, "net_x324");

      // Hold and blank
      tick(0, 100, 200, 1, 0, 0, "hold_a");
      tick(0, 320, 8,   1, 0, 0, "hold_b");
      tick(1, 100, 0,   0, 0, 0, "blank_y0");
      tick(0, 100, 5,   1, 0, 0, "hold_blank");

      // Flash sequence
      tick(1, 100, 3, 1, 0, 1, "flash_go");
      for (int f = 0; f < 34; f++) begin
         tick(1, 100, 2,   1, 1, 0, "flash_fs");
         tick(1, 200, 475, 1, 0, 0, "flash_px");
      end

      // Collision: score together with frame_start while 5 frames remain
      tick(1, 100, 3, 1, 0, 1, "coll_go");
      for (int f = 0; f < 25; f++) tick(1, 100, 2, 1, 1, 0, "coll_pre");
      tick(1, 100, 4, 1, 1, 1, "coll_hit");
      for (int f = 0; f < 31; f++) begin
         tick(1, 300, 478, 1, 1, 0, "coll_post");
      end

      // Reset in the middle of a flash with a lit pixel
      tick(1, 100, 3, 1, 0, 1, "rflash_go");
      for (int f = 0; f < 3; f++) tick(1, 100, 2, 1, 1, 0, "rflash_fs");
      do_reset("reset_mid_flash");
      tick(0, 100, 2, 1, 0, 0, "after_reset");
      tick(1, 100, 2, 1, 0, 0, "after_reset_px");

      // Net scroll
      for (int f = 0; f < 3; f++) tick(0, 0, 0, 0, 1, 0, "scroll_fs");
      tick(1, 320, 6, 1, 0, 0, "scroll_y6");
      tick(1, 320, 8, 1, 0, 0, "scroll_y8");
      for (int f = 0; f < 13; f++) tick(0, 0, 0, 0, 1, 0, "scroll_wrap_fs");
      tick(1, 320, 8, 1, 0, 0, "wrap_y8");
      tick(1, 320, 9, 1, 0, 0, "wrap_y9");

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         int xx;
         int yy;
         xx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(310, 330)) : int'($urandom_range(0, 1023));
         yy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) :
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(460, 490)) : int'($urandom_range(0, 1023));
         tick(bit'($urandom_range(0, 3) != 0), xx, yy, bit'($urandom_range(0, 4) != 0),
              bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 79) == 0), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
